// File: rtl/cvxif_result_pkg.sv
// ============================================================================
// cvxif_result_pkg : default parameters and occupancy-width helper for the
//                    CV-X-IF result queue.  Revision 1.0
// ============================================================================
`default_nettype none

package cvxif_result_pkg;

  localparam int unsigned NR_CHANNELS_DEF  = 2;
  localparam int unsigned DEPTH_DEF        = 4;
  localparam int unsigned XLEN_DEF         = 64;
  localparam int unsigned ID_WIDTH_DEF     = 4;
  localparam int unsigned HARTID_WIDTH_DEF = 1;

  // Width able to hold 0..depth inclusive.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cvxif_rr_arb.sv
// ============================================================================
// cvxif_rr_arb : round-robin arbiter, one-hot grant, priority moves to the
//                channel after the granted one.  Revision 1.0
// ============================================================================
`default_nettype none

module cvxif_rr_arb
  import cvxif_result_pkg::*;
#(
  parameter int unsigned NrReq = NR_CHANNELS_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NrReq-1:0] req_i,
  output logic [NrReq-1:0] gnt_o
);

  localparam int unsigned PtrW = (NrReq > 1) ? $clog2(NrReq) : 1;

  logic [PtrW-1:0]  prio_q, prio_d;
  logic [NrReq-1:0] mask;
  logic [NrReq-1:0] req_hi;

  // Requests at or above the priority pointer win first; otherwise wrap
  // around to the lowest requester.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < NrReq; i++) begin
      mask[i] = (PtrW'(i) >= prio_q);
    end
    req_hi = req_i & mask;
    gnt_o  = (|req_hi) ? (req_hi & (~req_hi + NrReq'(1)))
                       : (req_i  & (~req_i  + NrReq'(1)));
    prio_d = prio_q;
    for (int unsigned i = 0; i < NrReq; i++) begin
      if (gnt_o[i]) begin
        prio_d = (i == NrReq - 1) ? '0 : PtrW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q <= '0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cvxif_result_queue.sv
// ============================================================================
// cvxif_result_queue : multi-channel result FIFO toward the CPU with
//                      round-robin intake.  Optional same-cycle bypass when
//                      empty: CVXIF_RESULT_BYPASS_EN.  Revision 1.0
// ============================================================================
`default_nettype none

module cvxif_result_queue
  import cvxif_result_pkg::*;
#(
  parameter int unsigned NrChannels  = NR_CHANNELS_DEF,
  parameter int unsigned Depth       = DEPTH_DEF,
  parameter int unsigned XLEN        = XLEN_DEF,
  parameter int unsigned IdWidth     = ID_WIDTH_DEF,
  parameter int unsigned HartIdWidth = HARTID_WIDTH_DEF
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     flush_i,
  input  logic [NrChannels-1:0]                    chan_valid_i,
  output logic [NrChannels-1:0]                    chan_ready_o,
  input  logic [NrChannels-1:0][XLEN-1:0]          chan_data_i,
  input  logic [NrChannels-1:0][4:0]               chan_rd_i,
  input  logic [NrChannels-1:0]                    chan_we_i,
  input  logic [NrChannels-1:0][IdWidth-1:0]       chan_id_i,
  input  logic [NrChannels-1:0][HartIdWidth-1:0]   chan_hartid_i,
  output logic                                     result_valid_o,
  input  logic                                     result_ready_i,
  output logic [XLEN-1:0]                          result_data_o,
  output logic [4:0]                               result_rd_o,
  output logic                                     result_we_o,
  output logic [IdWidth-1:0]                       result_id_o,
  output logic [HartIdWidth-1:0]                   result_hartid_o,
  output logic [occ_width(Depth)-1:0]              count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = occ_width(Depth);

  typedef struct packed {
    logic [XLEN-1:0]        data;
    logic [4:0]             rd;
    logic                   we;
    logic [IdWidth-1:0]     id;
    logic [HartIdWidth-1:0] hartid;
  } entry_t;

  entry_t                mem_q [Depth];
  logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  empty, full, can_push, push, wr_en, rd_en;
  logic [NrChannels-1:0] arb_req, gnt;
  entry_t                in_entry, head, out_entry;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CntW'(Depth));
  // A full queue still takes one push when the head leaves this cycle.
  assign can_push = !flush_i && (!full || result_ready_i);
  assign arb_req  = chan_valid_i & {NrChannels{can_push}};

  cvxif_rr_arb #(
    .NrReq (NrChannels)
  ) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (arb_req),
    .gnt_o (gnt)
  );

  assign chan_ready_o = gnt;
  assign push         = |gnt;

  always_comb begin
    in_entry = '0;
    for (int unsigned i = 0; i < NrChannels; i++) begin
      if (gnt[i]) begin
        in_entry.data   = chan_data_i[i];
        in_entry.rd     = chan_rd_i[i];
        in_entry.we     = chan_we_i[i];
        in_entry.id     = chan_id_i[i];
        in_entry.hartid = chan_hartid_i[i];
      end
    end
  end

  assign head  = mem_q[rptr_q];
  assign rd_en = !empty && result_ready_i;

`ifdef CVXIF_RESULT_BYPASS_EN
  logic bypass;
  assign bypass         = empty && push;
  assign result_valid_o = !empty || push;
  assign wr_en          = push && !(bypass && result_ready_i);
  assign out_entry      = bypass ? in_entry : head;
`else
  assign result_valid_o = !empty;
  assign wr_en          = push;
  assign out_entry      = head;
`endif

  assign result_data_o   = out_entry.data;
  assign result_rd_o     = out_entry.rd;
  assign result_we_o     = out_entry.we;
  assign result_id_o     = out_entry.id;
  assign result_hartid_o = out_entry.hartid;
  assign count_o         = cnt_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (wr_en) wptr_d = wptr_q + PtrW'(1);
      if (rd_en) rptr_d = rptr_q + PtrW'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Payload storage carries no reset; only valid slots are ever presented.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wptr_q] <= in_entry;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cvxif_result_queue.sv
// ============================================================================
// tb_cvxif_result_queue : self-checking bench for cvxif_result_queue
//                         (default parameters; follows CVXIF_RESULT_BYPASS_EN).
//                         Revision 1.0
// ============================================================================
`default_nettype none

module tb_cvxif_result_queue;

  localparam int N     = 2;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [N-1:0]     valid;
  logic [N-1:0]     ready;
  logic [N-1:0][63:0] cdata;
  logic [N-1:0][4:0]  crd;
  logic [N-1:0]       cwe;
  logic [N-1:0][3:0]  cid;
  logic [N-1:0][0:0]  chart;
  logic             res_valid;
  logic             res_ready;
  logic [63:0]      res_data;
  logic [4:0]       res_rd;
  logic             res_we;
  logic [3:0]       res_id;
  logic [0:0]       res_hart;
  logic [2:0]       count;

  int total = 0;
  int bad   = 0;

  cvxif_result_queue dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (flush),
    .chan_valid_i    (valid),
    .chan_ready_o    (ready),
    .chan_data_i     (cdata),
    .chan_rd_i       (crd),
    .chan_we_i       (cwe),
    .chan_id_i       (cid),
    .chan_hartid_i   (chart),
    .result_valid_o  (res_valid),
    .result_ready_i  (res_ready),
    .result_data_o   (res_data),
    .result_rd_o     (res_rd),
    .result_we_o     (res_we),
    .result_id_o     (res_id),
    .result_hartid_o (res_hart),
    .count_o         (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        we;
    logic [3:0]  id;
    logic [0:0]  hart;
  } ent_t;

  ent_t        mq[$];
  int          mptr = 0;
  logic [63:0] emitted[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ent_t chan_ent(input int c);
    ent_t e;
    e.data = cdata[c]; e.rd = crd[c]; e.we = cwe[c]; e.id = cid[c]; e.hart = chart[c];
    return e;
  endfunction

  // Expected grant: first valid channel at or after the priority channel.
  function automatic int mgrant();
    if (flush) return -1;
    if (mq.size() == DEPTH && !res_ready) return -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (mptr + k) % N;
      if (valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic drive(input logic [N-1:0] v, input logic rr, input logic fl,
                       input logic [63:0] d0, input logic [63:0] d1);
    valid = v; res_ready = rr; flush = fl;
    cdata[0] = d0; cdata[1] = d1;
    crd = '0; cwe = '0; cid = '0; chart = '0;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic step(input string tag);
    int         g;
    ent_t       e;
    bit         ev;
    bit         consumed;
    logic [N-1:0] erdy;
    #1;
    g    = mgrant();
    erdy = '0;
    if (g >= 0) erdy[g] = 1'b1;
    ev = (mq.size() != 0);
    if (ev) e = mq[0];
`ifdef CVXIF_RESULT_BYPASS_EN
    if (!ev && g >= 0) begin
      ev = 1'b1;
      e  = chan_ent(g);
    end
`endif
    chk({tag, "_ready"}, 64'(ready), 64'(erdy));
    chk({tag, "_valid"}, 64'(res_valid), 64'(ev));
    chk({tag, "_count"}, 64'(count), 64'(mq.size()));
    if (ev) begin
      chk({tag, "_data"}, res_data, e.data);
      chk({tag, "_fields"}, {51'd0, res_rd, res_we, res_id, res_hart},
                            {51'd0, e.rd, e.we, e.id, e.hart});
    end
    if (res_valid && res_ready) emitted.push_back(res_data);
    @(posedge clk);
    consumed = 1'b0;
    if (flush) begin
      mq.delete();
    end else begin
      if (mq.size() != 0 && res_ready) void'(mq.pop_front());
`ifdef CVXIF_RESULT_BYPASS_EN
      else if (mq.size() == 0 && g >= 0 && res_ready) consumed = 1'b1;
`endif
      if (g >= 0 && !consumed) mq.push_back(chan_ent(g));
    end
    if (g >= 0) mptr = (g + 1) % N;
    @(negedge clk);
  endtask

  typedef struct {
    logic [N-1:0] v;
    logic         rr;
    logic         fl;
    logic [63:0]  d0;
    logic [63:0]  d1;
    logic [N-1:0] e_rdy;
    logic [2:0]   e_cnt;
    logic [63:0]  e_data;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // Alternating fill to full, pop+push at full, drain, flush with ready high.
    tbl[0] = '{2'b11, 1'b0, 1'b0, 64'h10, 64'h20, 2'b01, 3'd0, 64'h0};
    tbl[1] = '{2'b11, 1'b0, 1'b0, 64'h11, 64'h21, 2'b10, 3'd1, 64'h10};
    tbl[2] = '{2'b11, 1'b0, 1'b0, 64'h12, 64'h22, 2'b01, 3'd2, 64'h10};
    tbl[3] = '{2'b11, 1'b0, 1'b0, 64'h13, 64'h23, 2'b10, 3'd3, 64'h10};
    tbl[4] = '{2'b11, 1'b0, 1'b0, 64'h14, 64'h24, 2'b00, 3'd4, 64'h10};
    tbl[5] = '{2'b10, 1'b1, 1'b0, 64'h15, 64'h25, 2'b10, 3'd4, 64'h10};
    tbl[6] = '{2'b00, 1'b1, 1'b0, 64'h16, 64'h26, 2'b00, 3'd4, 64'h21};
    tbl[7] = '{2'b00, 1'b0, 1'b0, 64'h17, 64'h27, 2'b00, 3'd3, 64'h12};
    tbl[8] = '{2'b11, 1'b1, 1'b1, 64'h18, 64'h28, 2'b00, 3'd3, 64'h12};
    tbl[9] = '{2'b00, 1'b0, 1'b0, 64'h19, 64'h29, 2'b00, 3'd0, 64'h0};

    rst = 1'b1;
    drive('0, 1'b0, 1'b0, 64'h0, 64'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_valid", 64'(res_valid), 64'd0);
    chk("reset_ready", 64'(ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].rr, tbl[i].fl, tbl[i].d0, tbl[i].d1);
      #1;
      chk($sformatf("tbl%0d_ready", i), 64'(ready), 64'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].e_cnt));
      if (tbl[i].e_cnt != 0) begin
        chk($sformatf("tbl%0d_valid", i), 64'(res_valid), 64'd1);
        chk($sformatf("tbl%0d_data", i), res_data, tbl[i].e_data);
      end
      step($sformatf("tbl%0d", i));
    end

    // Channel 0 streams two results straight through to a ready CPU.
    emitted.delete();
    drive(2'b01, 1'b1, 1'b0, 64'h11, 64'h0); step("seq32");
    drive(2'b01, 1'b1, 1'b0, 64'h22, 64'h0); step("seq32");
    drive(2'b00, 1'b1, 1'b0, 64'h0, 64'h0);
    for (int k = 0; k < 4; k++) step("seq32");
    chk("seq32_n_emitted", 64'(emitted.size()), 64'd2);
    if (emitted.size() >= 2) begin
      chk("seq32_first", emitted[0], 64'h11);
      chk("seq32_second", emitted[1], 64'h22);
    end
    chk("seq32_count", 64'(count), 64'd0);

    // Asynchronous reset with two entries queued and priority on channel 1.
    drive(2'b01, 1'b0, 1'b0, 64'h31, 64'h0); step("seq36");
    drive(2'b01, 1'b0, 1'b0, 64'h32, 64'h0); step("seq36");
    drive(2'b00, 1'b0, 1'b0, 64'h0, 64'h0);
    #1;
    chk("seq36_pre_count", 64'(count), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("seq36_valid", 64'(res_valid), 64'd0);
    chk("seq36_count", 64'(count), 64'd0);
    mq.delete();
    mptr = 0;
    @(negedge clk);
    rst = 1'b0;
    drive(2'b11, 1'b0, 1'b0, 64'h41, 64'h42);
    #1;
    chk("seq36_grant", 64'(ready), 64'd1);
    step("seq36");
    drive(2'b00, 1'b1, 1'b0, 64'h0, 64'h0);
    repeat (2) step("drain");

`ifdef CVXIF_RESULT_BYPASS_EN
    drive(2'b01, 1'b1, 1'b0, 64'hAB, 64'h0);
    #1;
    chk("byp_valid", 64'(res_valid), 64'd1);
    chk("byp_data", res_data, 64'hAB);
    step("byp");
    drive(2'b00, 1'b0, 1'b0, 64'h0, 64'h0);
    #1;
    chk("byp_count", 64'(count), 64'd0);
    step("byp");
`endif

    for (int k = 0; k < 400; k++) begin
      valid     = N'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      for (int c = 0; c < N; c++) begin
        cdata[c] = {$urandom, $urandom};
        crd[c]   = 5'($urandom);
        cwe[c]   = 1'($urandom);
        cid[c]   = 4'($urandom);
        chart[c] = 1'($urandom);
      end
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cvxif_result_queue.md
CVXIF_RESULT_QUEUE -- requirements
Module: cvxif_result_queue

Interface
REQ-001 Parameter NrChannels, default 2, number of execution-unit result channels (1..8).
REQ-002 Parameter Depth, default 4, queue entries (power of two, >=2).
REQ-003 Parameter XLEN, default 64, result data width.
REQ-004 Parameter IdWidth, default 4; HartIdWidth, default 1; widths of id and hartid fields.
REQ-005 Port clk_i  input  1  single clock; all state updates on rising edge.
REQ-006 Port rst_i  input  1  reset, asynchronous, active-high.
REQ-007 Port flush_i  input  1  synchronous clear of all queued results.
REQ-008 Port chan_valid_i  input  NrChannels  per-channel result valid.
REQ-009 Port chan_ready_o  output  NrChannels  per-channel accept; at most one bit high per cycle.
REQ-010 Port chan_data_i / chan_rd_i / chan_we_i / chan_id_i / chan_hartid_i  input  NrChannels x (XLEN / 5 / 1 / IdWidth / HartIdWidth)  per-channel result fields.
REQ-011 Port result_valid_o  output  1  head entry valid toward CPU.
REQ-012 Port result_ready_i  input  1  CPU accepts head entry.
REQ-013 Port result_data_o / result_rd_o / result_we_o / result_id_o / result_hartid_o  output  XLEN / 5 / 1 / IdWidth / HartIdWidth  head entry fields.
REQ-014 Port count_o  output  $clog2(Depth+1)  current occupancy.

Function
REQ-015 Channel i handshake SHALL complete when chan_valid_i[i] and chan_ready_o[i] are both high; the granted entry is written at queue tail.
REQ-016 Grant SHALL be round-robin among valid channels, starting from the channel after the last accepted one; priority pointer advances only on a completed handshake.
REQ-017 chan_ready_o SHALL be all-zero when queue is full and no pop occurs that cycle; full with simultaneous pop SHALL allow one push.
REQ-018 chan_ready_o SHALL depend combinationally on chan_valid_i, fill state, result_ready_i and flush_i only.
REQ-019 result_valid_o SHALL equal (count_o != 0); output fields SHALL present the head entry, stable while result_valid_o high and result_ready_i low.
REQ-020 Pop SHALL occur when result_valid_o and result_ready_i are both high.
REQ-021 Push-to-visible latency SHALL be one cycle (entry pushed in cycle N appears at head no earlier than N+1).
REQ-022 Order SHALL be FIFO across all channels; pointers wrap modulo Depth.
REQ-023 Simultaneous push and pop SHALL keep count_o unchanged.
REQ-024 flush_i high SHALL force chan_ready_o to zero, discard all entries, clear count_o next cycle; priority pointer is kept; flush overrides concurrent pop.
REQ-025 Pop when empty and push when full-without-pop SHALL be impossible by construction.

Reset
REQ-026 On rst_i high, asynchronously: count_o=0, result_valid_o=0, read/write pointers=0, round-robin pointer=channel 0.
REQ-027 Reset mid-operation SHALL drop all queued entries; entry storage need not be reset; result_* fields are don't-care while result_valid_o=0.

Configuration
REQ-028 Macro CVXIF_RESULT_BYPASS_EN defined: when queue empty (and no flush), granted channel result SHALL appear on result_* in the same cycle with result_valid_o high; if result_ready_i is high it is consumed without being written.
REQ-029 Macro undefined: no bypass; REQ-021 latency applies unconditionally.

Structure
REQ-030 Package cvxif_result_pkg SHALL hold default parameter constants and the occupancy-width helper function; entry struct is local to the module.
REQ-031 Round-robin arbitration SHALL be a sub-module cvxif_rr_arb (request vector in, one-hot grant out, pointer update on handshake).

Verification
REQ-032 Single channel 0 pushes data 0x11, 0x22, result_ready_i=1 -> results emitted 0x11 then 0x22, count_o back to 0.
REQ-033 Both channels valid every cycle, result_ready_i=0, Depth=4 -> grants alternate 0,1,0,1, count_o reaches 4, chan_ready_o=0 thereafter.
REQ-034 Full queue, result_ready_i=1, channel 1 valid -> pop and push same cycle, count_o stays 4, FIFO order preserved.
REQ-035 Queue holds 3 entries, flush_i pulsed with result_ready_i=1 -> next cycle count_o=0, result_valid_o=0, no channel accepted in flush cycle.
REQ-036 rst_i asserted mid-stream with 2 entries queued -> result_valid_o low immediately, count_o=0, next grant to channel 0.
REQ-037 With CVXIF_RESULT_BYPASS_EN, empty queue, channel 0 valid 0xAB, result_ready_i=1 -> result_data_o=0xAB same cycle, count_o stays 0.
